pio_addr_fetch: RTL
===================

PIO_ADDR_FETCH -- requirements
Module: pio_addr_fetch

Interface
REQ-001 Parameter DATA_W, default 16: width of memory read data and output stream data.
REQ-002 Parameter BURST_LOG2, default 4: log2 of beats per burst (BURST_LEN = 2^BURST_LOG2).
REQ-003 Parameter MEM_AW, default 12: memory address width; SHALL equal 8 + BURST_LOG2.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 addr_in  in  8  burst select index, driven by the upstream 8-bit PIO output register (level only, no strobe).
REQ-007 mem_rd  out  1  one-cycle read request to synchronous RAM.
REQ-008 mem_addr  out  MEM_AW  read address = {burst index, beat index}.
REQ-009 mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_rd.
REQ-010 out_valid  out  1  stream beat valid.
REQ-011 out_data  out  DATA_W  stream beat data.
REQ-012 out_last  out  1  high on final beat of a burst.
REQ-013 out_ready  in  1  downstream accept; beat transfers when out_valid and out_ready are both high.
REQ-014 busy  out  1  high while state is not IDLE.
REQ-015 pend  out  1  high while a queued index awaits service.

Function
REQ-016 Block SHALL register addr_in into addr_q every cycle; a change SHALL be detected when addr_in != addr_q.
REQ-017 FSM states: IDLE, FETCH, DRAIN.
REQ-018 IDLE: on change, latch base = addr_in, clear beat counter, go to FETCH at the same edge.
REQ-019 FETCH: assert mem_rd with mem_addr = {base, beat} only when FIFO occupancy + reads in flight - pop this cycle < 2; increment beat on each issue.
REQ-020 FETCH -> DRAIN on the edge issuing beat BURST_LEN-1.
REQ-021 DRAIN -> IDLE on the edge the beat with out_last is accepted, or directly into FETCH if pend is set (base = pending index, pend cleared).
REQ-022 mem_rdata SHALL be written into a 2-entry output FIFO the cycle after mem_rd; the FIFO SHALL never overflow and SHALL never be written when full.
REQ-023 out_valid = FIFO not empty; out_data/out_last from FIFO head; out_data/out_last SHALL hold stable while out_valid high and out_ready low.
REQ-024 out_last tag SHALL travel with the beat whose beat index was BURST_LEN-1.
REQ-025 Latency: first out_valid asserts 3 rising edges after the edge that first samples the changed addr_in.
REQ-026 Throughput: with out_ready held high, BURST_LEN beats on BURST_LEN consecutive cycles.
REQ-027 Change detected while busy: store index as pending, set pend; a later change while pend is set overwrites the stored index (latest wins); the active burst SHALL NOT be aborted.
REQ-028 Change back to the active burst index while busy SHALL still be queued as pending.
REQ-029 Pending burst's first mem_rd SHALL occur in the cycle after the last beat of the prior burst is accepted.
REQ-030 out_ready low for any duration SHALL lose or duplicate no beat.

Reset
REQ-031 On reset_n low, asynchronously: state=IDLE, addr_q=0, beat=0, FIFO empty, in-flight=0, pend=0, mem_rd=0, mem_addr=0, out_valid=0, out_last=0, busy=0.
REQ-032 Reset mid-burst SHALL discard all queued and in-flight data; a RAM response arriving after reset release SHALL be ignored.
REQ-033 Index 0 present on addr_in at reset release SHALL NOT start a burst; any nonzero value SHALL start one on the first edge after release.

Verification
REQ-034 RAM word = address; out_ready=1; addr_in 0->5 -> 16 consecutive beats 0x050..0x05F, out_last only on 0x05F, first out_valid 3 edges after change.
REQ-035 addr_in->3, out_ready toggled 1-of-3 cycles -> beats 0x030..0x03F in order, no gaps, repeats or loss; busy falls after last accept.
REQ-036 addr_in->2, then 7 then 9 during burst -> full burst 0x020..0x02F, then burst 0x090..0x09F only; pend high from first change until burst 9 starts.
REQ-037 addr_in 0->0xFF -> beats 0xFF0..0xFFF, mem_addr no wrap beyond 0xFFF.
REQ-038 Assert reset_n low at beat 6 of a burst with out_ready=0 -> all outputs zero immediately; after release with addr_in unchanged nonzero, a fresh burst starts from beat 0.
REQ-039 addr_in stays 0 after reset for 100 cycles -> mem_rd never asserts, busy=0.

Source files
------------

// File: rtl/pio_addr_fetch_if.sv
// rtl/pio_addr_fetch_if.sv - RAM read port and output beat stream of the PIO burst fetcher
interface pio_addr_fetch_if #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 12
) ();
  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output mem_rd, mem_addr, out_valid, out_data, out_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, out_valid, out_data, out_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/pio_addr_fetch.sv
// rtl/pio_addr_fetch.sv - fetches a RAM burst selected by a PIO index and streams it out
module pio_addr_fetch #(
  parameter int DATA_W     = 16,
  parameter int BURST_LOG2 = 4,
  parameter int MEM_AW     = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           addr_in,
  pio_addr_fetch_if.master     bus,
  output logic                 busy,
  output logic                 pend
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  localparam logic [BURST_LOG2-1:0] BEAT_MAX = '1;

  state_t                state, state_nxt;
  logic [7:0]            addr_q, base, pend_idx;
  logic [BURST_LOG2-1:0] beat;
  logic                  pend_q;
  logic                  change, issue, last_issue, credit_ok;
  logic                  rd_vld, rd_last;
  logic                  pop, last_pop, drain_done, drain_restart;
  logic [MEM_AW-1:0]     rd_addr;

  logic [DATA_W:0]       fifo_mem [2];
  logic [DATA_W:0]       head;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;

  assign change        = (addr_in != addr_q);
  assign last_issue    = (beat == BEAT_MAX);
  assign rd_addr       = {base, beat};
  assign head          = fifo_mem[rd_ptr];
  assign pop           = bus.out_valid && bus.out_ready;
  assign last_pop      = pop && bus.out_last;
  assign drain_done    = (state == S_DRAIN) && last_pop;
  assign drain_restart = drain_done && (pend_q || change);
  // Occupancy plus the read whose data is on mem_rdata now, minus this cycle's pop, must leave room.
  assign credit_ok     = ({1'b0, fifo_cnt} + {2'b00, rd_vld}) < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (change) state_nxt = S_FETCH;
      S_FETCH: if (issue && last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done) state_nxt = (pend_q || change) ? S_FETCH : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    issue        = (state == S_FETCH) && credit_ok;
    bus.mem_rd   = issue;
    bus.mem_addr = rd_addr;
    pend         = pend_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      base     <= '0;
      beat     <= '0;
      pend_q   <= 1'b0;
      pend_idx <= '0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      addr_q  <= addr_in;
      rd_vld  <= issue;
      rd_last <= issue && last_issue;
      if (state == S_IDLE && change) begin
        base <= addr_in;
        beat <= '0;
      end else if (issue) begin
        beat <= beat + 1'b1;
      end else if (drain_restart) begin
        base <= change ? addr_in : pend_idx;
        beat <= '0;
      end
      // A change landing on the final accept is consumed directly by the restart.
      if (drain_done) begin
        pend_q <= 1'b0;
      end else if (busy && change) begin
        pend_q   <= 1'b1;
        pend_idx <= addr_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld) fifo_mem[wr_ptr] <= {rd_last, bus.mem_rdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (rd_vld) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

  always_comb begin
    bus.out_valid = (fifo_cnt != 2'd0);
    bus.out_data  = bus.out_valid ? head[DATA_W-1:0] : '0;
    bus.out_last  = bus.out_valid ? head[DATA_W] : 1'b0;
  end
endmodule
